// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 round-robin CBus arbiter.
// Holds each grant until the downstream reports the final beat.
package cbus_pkg;

   localparam logic [3:0] MLEN1  = 4'd0;
   localparam logic [3:0] MLEN2  = 4'd1;
   localparam logic [3:0] MLEN4  = 4'd3;
   localparam logic [3:0] MLEN8  = 4'd7;
   localparam logic [3:0] MLEN16 = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  cbus_req_t            ireqs  [NUM_INPUTS],
   output cbus_resp_t           oresps [NUM_INPUTS],
   output cbus_req_t            oreq,
   input  cbus_resp_t           oresp,
   output logic                 busy,
   output logic [IDX_WIDTH-1:0] grant_idx
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX =
      IDX_WIDTH'(NUM_INPUTS - 1);

   state_t               state;
   logic [IDX_WIDTH-1:0] sel;
   logic [IDX_WIDTH-1:0] prio;
   logic [IDX_WIDTH-1:0] pick;
   logic [IDX_WIDTH-1:0] prio_nxt;
   logic                 any;
   logic                 done;

   // first valid requester, scanning upward from prio with wrap
   always_comb begin
      pick = prio;
      any  = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (!any &&
             ireqs[(int'(prio) + k) % NUM_INPUTS].valid) begin
            pick = IDX_WIDTH'((int'(prio) + k) % NUM_INPUTS);
            any  = 1'b1;
         end
      end
   end

   // completed index drops to lowest priority
   assign prio_nxt = (sel == LAST_IDX) ? '0 : sel + 1'b1;
   assign done     = oresp.ready && oresp.last;

   // arbitration FSM; oresp only matters while a grant is held
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         sel   <= '0;
         prio  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  sel   <= pick;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  prio  <= prio_nxt;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // route the granted request down and the response back up
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         oresps[i] = '0;
      end
      if (state == BUSY) begin
         oreq        = ireqs[sel];
         oresps[sel] = oresp;
      end
   end

   assign busy      = (state == BUSY);
   assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed vector bench for the CBus arbiter.
// Main instance has two inputs; a three-input instance covers wrap.
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h8000_0010;
   localparam logic [31:0] A2 = 32'h2000_0040;

   logic       clk = 1'b0;
   logic       resetn;
   cbus_req_t  ireqs  [2];
   cbus_resp_t oresps [2];
   cbus_req_t  oreq;
   cbus_resp_t oresp;
   logic       busy;
   logic [0:0] gidx;

   logic       resetn3;
   cbus_req_t  ireqs3  [3];
   cbus_resp_t oresps3 [3];
   cbus_req_t  oreq3;
   cbus_resp_t oresp3;
   logic       busy3;
   logic [1:0] gidx3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cbus_rr_arbiter #(.NUM_INPUTS(2)) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .ireqs    (ireqs),
      .oresps   (oresps),
      .oreq     (oreq),
      .oresp    (oresp),
      .busy     (busy),
      .grant_idx(gidx)
   );

   cbus_rr_arbiter #(.NUM_INPUTS(3)) u_dut3 (
      .clk      (clk),
      .resetn   (resetn3),
      .ireqs    (ireqs3),
      .oresps   (oresps3),
      .oreq     (oreq3),
      .oresp    (oresp3),
      .busy     (busy3),
      .grant_idx(gidx3)
   );

   typedef struct {
      logic [4:0]  in;
      logic [31:0] rd;
      logic [3:0]  ef;
      logic        gi;
      logic [31:0] oa;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(string nm, logic [63:0] act,
                      logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic cbus_req_t mkreq(logic v, logic [31:0] a,
                                       logic [3:0] len);
      cbus_req_t r;
      r        = '0;
      r.valid  = v;
      r.addr   = a;
      r.len    = len;
      r.size   = 3'd2;
      r.strobe = 4'hf;
      return r;
   endfunction

   task automatic drive(logic v0, logic [3:0] l0, logic v1,
                        logic [3:0] l1, logic rdy, logic lst,
                        logic [31:0] d);
      ireqs[0]   = mkreq(v0, A0, l0);
      ireqs[1]   = mkreq(v1, A1, l1);
      oresp.ready = rdy;
      oresp.last  = lst;
      oresp.data  = d;
   endtask

   initial begin
      tbl[0]  = '{5'b00000, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[1]  = '{5'b10000, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[2]  = '{5'b10011, 32'hCAFEF00D, 4'b0000, 1'b0,
                  32'h0, 32'h0, 32'h0};
      tbl[3]  = '{5'b10000, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[4]  = '{5'b10100, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[5]  = '{5'b10100, 32'h0, 4'b1100, 1'b1, A1, 32'h0, 32'h0};
      tbl[6]  = '{5'b10100, 32'h0, 4'b1100, 1'b1, A1, 32'h0, 32'h0};
      tbl[7]  = '{5'b10111, 32'hDEADBEEF, 4'b1101, 1'b1,
                  A1, 32'h0, 32'hDEADBEEF};
      tbl[8]  = '{5'b10000, 32'h0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0};
      tbl[9]  = '{5'b11100, 32'h0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0};
      tbl[10] = '{5'b11111, 32'h11, 4'b1110, 1'b0, A0, 32'h11, 32'h0};
      tbl[11] = '{5'b11100, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[12] = '{5'b11111, 32'h22, 4'b1101, 1'b1, A1, 32'h0, 32'h22};
      tbl[13] = '{5'b11100, 32'h0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0};
      tbl[14] = '{5'b11111, 32'h33, 4'b1110, 1'b0, A0, 32'h33, 32'h0};
      tbl[15] = '{5'b11100, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0};
      tbl[16] = '{5'b11111, 32'h44, 4'b1101, 1'b1, A1, 32'h0, 32'h44};
      tbl[17] = '{5'b10000, 32'h0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0};

      resetn  = 1'b0;
      resetn3 = 1'b0;
      drive(1'b0, MLEN1, 1'b0, MLEN1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) ireqs3[i] = '0;
      oresp3 = '0;
      tick();

      for (int i = 0; i < 18; i++) begin
         resetn = tbl[i].in[4];
         drive(tbl[i].in[3], MLEN1, tbl[i].in[2], MLEN1,
               tbl[i].in[1], tbl[i].in[0], tbl[i].rd);
         #1;
         chk($sformatf("v%0d.valid", i), 64'(oreq.valid),
             64'(tbl[i].ef[3]));
         chk($sformatf("v%0d.addr", i), 64'(oreq.addr),
             64'(tbl[i].oa));
         chk($sformatf("v%0d.busy", i), 64'(busy),
             64'(tbl[i].ef[2]));
         chk($sformatf("v%0d.gidx", i), 64'(gidx),
             64'(tbl[i].gi));
         chk($sformatf("v%0d.r0", i),
             64'({oresps[0].ready, oresps[0].data}),
             64'({tbl[i].ef[1], tbl[i].d0}));
         chk($sformatf("v%0d.r1", i),
             64'({oresps[1].ready, oresps[1].data}),
             64'({tbl[i].ef[0], tbl[i].d1}));
         tick();
      end

      // burst hold: 0 keeps the grant for four beats
      drive(1'b1, MLEN4, 1'b1, MLEN1, 1'b0, 1'b0, 32'h0);
      tick();
      for (int b = 0; b < 4; b++) begin
         drive(1'b1, MLEN4, 1'b1, MLEN1, 1'b1, (b == 3),
               32'hB0 + 32'(b));
         #1;
         chk($sformatf("burst%0d.gidx", b), 64'(gidx), 64'd0);
         chk($sformatf("burst%0d.busy", b), 64'(busy), 64'd1);
         chk($sformatf("burst%0d.len", b), 64'(oreq.len),
             64'(MLEN4));
         chk($sformatf("burst%0d.d0", b), 64'(oresps[0].data),
             64'(32'hB0 + 32'(b)));
         chk($sformatf("burst%0d.r1", b), 64'(oresps[1]), 64'd0);
         tick();
      end
      drive(1'b0, MLEN4, 1'b1, MLEN1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("burst.gap_busy", 64'(busy), 64'd0);
      chk("burst.gap_valid", 64'(oreq.valid), 64'd0);
      tick();
      chk("burst.next_gidx", 64'(gidx), 64'd1);
      chk("burst.next_addr", 64'(oreq.addr), 64'(A1));
      drive(1'b0, MLEN4, 1'b1, MLEN1, 1'b1, 1'b1, 32'h55);
      #1;
      chk("burst.next_d1", 64'(oresps[1].data), 64'h55);
      tick();

      // valid drop during a grant keeps the grant
      drive(1'b0, MLEN1, 1'b1, MLEN1, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, MLEN1, 1'b0, MLEN1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("drop.valid", 64'(oreq.valid), 64'd0);
      chk("drop.busy", 64'(busy), 64'd1);
      chk("drop.gidx", 64'(gidx), 64'd1);
      tick();
      drive(1'b0, MLEN1, 1'b1, MLEN1, 1'b1, 1'b1, 32'h66);
      #1;
      chk("drop.restore", 64'(oreq.valid), 64'd1);
      chk("drop.d1", 64'(oresps[1].data), 64'h66);
      tick();

      // requester 0 completes so prio moves to 1
      drive(1'b1, MLEN1, 1'b0, MLEN1, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b1, MLEN1, 1'b0, MLEN1, 1'b1, 1'b1, 32'h0);
      #1;
      chk("pre.gidx", 64'(gidx), 64'd0);
      tick();

      // reset in the middle of a burst on requester 1
      drive(1'b0, MLEN1, 1'b1, MLEN4, 1'b0, 1'b0, 32'h0);
      tick();
      for (int b = 0; b < 2; b++) begin
         drive(1'b0, MLEN1, 1'b1, MLEN4, 1'b1, 1'b0, 32'hC0);
         #1;
         chk($sformatf("rst.beat%0d", b), 64'(gidx), 64'd1);
         tick();
      end
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int b = 0; b < 2; b++) begin
         drive(1'b0, MLEN1, 1'b0, MLEN4, 1'b1, (b == 1), 32'h77);
         #1;
         chk($sformatf("rst%0d.valid", b), 64'(oreq.valid), 64'd0);
         chk($sformatf("rst%0d.busy", b), 64'(busy), 64'd0);
         chk($sformatf("rst%0d.gidx", b), 64'(gidx), 64'd0);
         chk($sformatf("rst%0d.r0", b), 64'(oresps[0]), 64'd0);
         chk($sformatf("rst%0d.r1", b), 64'(oresps[1]), 64'd0);
         tick();
      end
      drive(1'b1, MLEN1, 1'b1, MLEN1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("rst.prio_gidx", 64'(gidx), 64'd0);
      drive(1'b0, MLEN1, 1'b0, MLEN1, 1'b1, 1'b1, 32'h0);
      tick();

      // three inputs: prio 2 wins, then wraps to 0
      resetn3 = 1'b1;
      ireqs3[1] = mkreq(1'b1, A1, MLEN1);
      tick();
      oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'h0};
      #1;
      chk("wrap.first", 64'(gidx3), 64'd1);
      tick();
      ireqs3[1] = '0;
      ireqs3[0] = mkreq(1'b1, A0, MLEN1);
      ireqs3[2] = mkreq(1'b1, A2, MLEN1);
      oresp3 = '0;
      tick();
      chk("wrap.win2", 64'(gidx3), 64'd2);
      chk("wrap.addr2", 64'(oreq3.addr), 64'(A2));
      oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'h88};
      #1;
      chk("wrap.d2", 64'(oresps3[2].data), 64'h88);
      chk("wrap.r0", 64'(oresps3[0]), 64'd0);
      tick();
      oresp3 = '0;
      #1;
      chk("wrap.gap", 64'(busy3), 64'd0);
      tick();
      chk("wrap.win0", 64'(gidx3), 64'd0);
      chk("wrap.busy0", 64'(busy3), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
